// File: rtl/cond_exec_stage_if.sv
// Decode-to-execute boundary bundle: decoder controls, hazard controls,
// ALU flags in, and the registered/gated execute-stage controls out.
interface cond_exec_stage_if;
    logic       stall_e;
    logic       flush_e;
    logic       pcs_d;
    logic       regw_d;
    logic       memw_d;
    logic       memtoreg_d;
    logic       alusrc_d;
    logic [2:0] alucontrol_d;
    logic [1:0] flagw_d;
    logic [3:0] cond_d;
    logic [3:0] alu_flags_e;
    logic [2:0] alucontrol_e;
    logic       alusrc_e;
    logic       memtoreg_e;
    logic       pcsrc_e;
    logic       regwrite_e;
    logic       memwrite_e;
    logic       cond_ex_e;
    logic       valid_e;
    logic [3:0] flags_q;

    modport master (
        output stall_e, flush_e, pcs_d, regw_d, memw_d, memtoreg_d, alusrc_d,
               alucontrol_d, flagw_d, cond_d, alu_flags_e,
        input  alucontrol_e, alusrc_e, memtoreg_e, pcsrc_e, regwrite_e,
               memwrite_e, cond_ex_e, valid_e, flags_q
    );

    modport slave (
        input  stall_e, flush_e, pcs_d, regw_d, memw_d, memtoreg_d, alusrc_d,
               alucontrol_d, flagw_d, cond_d, alu_flags_e,
        output alucontrol_e, alusrc_e, memtoreg_e, pcsrc_e, regwrite_e,
               memwrite_e, cond_ex_e, valid_e, flags_q
    );
endinterface

// File: rtl/cond_exec_stage.sv
// Execute-stage control register with NZCV flag state and predication:
// the condition field gates register/memory/PC writes and flag updates.
module cond_exec_stage (
    input  logic               clk,
    input  logic               rst_n,
    cond_exec_stage_if.slave   bus
);

    typedef struct packed {
        logic       valid;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       memtoreg;
        logic       alusrc;
        logic [2:0] alucontrol;
        logic [1:0] flagw;
        logic [3:0] cond;
    } ereg_t;

    // Condition evaluation against {N,Z,C,V}; 1111 is never-execute.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic res;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    ereg_t      e_r;
    ereg_t      e_next_s;
    logic [3:0] flags_r;
    logic [3:0] flags_next_s;
    logic       cond_ex_s;
    logic       flag_en_s;

    assign cond_ex_s = cond_check(e_r.cond, flags_r);
    assign flag_en_s = e_r.valid & cond_ex_s & ~bus.stall_e;

    // Next E-register contents: flush beats stall beats load.
    always_comb begin
        e_next_s = e_r;
        if (bus.flush_e) begin
            e_next_s = '0;
        end else if (bus.stall_e) begin
            e_next_s = e_r;
        end else begin
            e_next_s.valid      = 1'b1;
            e_next_s.pcs        = bus.pcs_d;
            e_next_s.regw       = bus.regw_d;
            e_next_s.memw       = bus.memw_d;
            e_next_s.memtoreg   = bus.memtoreg_d;
            e_next_s.alusrc     = bus.alusrc_d;
            e_next_s.alucontrol = bus.alucontrol_d;
            e_next_s.flagw      = bus.flagw_d;
            e_next_s.cond       = bus.cond_d;
        end
    end

    // Next flags: the NZ and CV halves update independently.
    always_comb begin
        flags_next_s = flags_r;
        if (flag_en_s && e_r.flagw[1]) begin
            flags_next_s[3:2] = bus.alu_flags_e[3:2];
        end else begin
            flags_next_s[3:2] = flags_r[3:2];
        end
        if (flag_en_s && e_r.flagw[0]) begin
            flags_next_s[1:0] = bus.alu_flags_e[1:0];
        end else begin
            flags_next_s[1:0] = flags_r[1:0];
        end
    end

    // E register and architectural flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_r     <= '0;
            flags_r <= 4'b0000;
        end else begin
            e_r     <= e_next_s;
            flags_r <= flags_next_s;
        end
    end

    assign bus.alucontrol_e = e_r.alucontrol;
    assign bus.alusrc_e     = e_r.alusrc;
    assign bus.memtoreg_e   = e_r.memtoreg;
    assign bus.pcsrc_e      = e_r.pcs  & e_r.valid & cond_ex_s;
    assign bus.regwrite_e   = e_r.regw & e_r.valid & cond_ex_s;
    assign bus.memwrite_e   = e_r.memw & e_r.valid & cond_ex_s;
    assign bus.cond_ex_e    = cond_ex_s;
    assign bus.valid_e      = e_r.valid;
    assign bus.flags_q      = flags_r;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage: predication, flag update, stall/flush, reset.
module tb_cond_exec_stage;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    cond_exec_stage_if bus ();

    cond_exec_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pcs, input logic regw, input logic memw,
                         input logic [2:0] aluc, input logic [1:0] flagw,
                         input logic [3:0] cond);
        bus.pcs_d        = pcs;
        bus.regw_d       = regw;
        bus.memw_d       = memw;
        bus.memtoreg_d   = 1'b0;
        bus.alusrc_d     = 1'b0;
        bus.alucontrol_d = aluc;
        bus.flagw_d      = flagw;
        bus.cond_d       = cond;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] all_outs();
        return {2'b00, bus.alucontrol_e, bus.alusrc_e, bus.memtoreg_e, bus.pcsrc_e,
                bus.regwrite_e, bus.memwrite_e, bus.cond_ex_e, bus.valid_e, bus.flags_q};
    endfunction

    function automatic logic model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        {n, z, cc, v} = f;
        case (c)
            4'h0: return z;        4'h1: return !z;
            4'h2: return cc;       4'h3: return !cc;
            4'h4: return n;        4'h5: return !n;
            4'h6: return v;        4'h7: return !v;
            4'h8: return cc && !z; 4'h9: return !cc || z;
            4'hA: return n == v;   4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        bus.stall_e     = 1'b0;
        bus.flush_e     = 1'b0;
        bus.alu_flags_e = 4'b0000;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 4'b0000);
        #12;
        chk("reset_outputs", all_outs(), 16'h0000);
        rst_n = 1'b1;

        // ADD AL regw
        drive(1'b0, 1'b1, 1'b0, 3'b010, 2'b00, 4'b1110);
        step();
        chk("add_regwrite", {15'd0, bus.regwrite_e}, 16'd1);
        chk("add_cond_ex", {15'd0, bus.cond_ex_e}, 16'd1);
        chk("add_flags", {12'd0, bus.flags_q}, 16'h0);
        chk("add_aluc", {13'd0, bus.alucontrol_e}, 16'd2);

        // CMP (Z set) then BEQ
        drive(1'b0, 1'b0, 1'b0, 3'b001, 2'b11, 4'b1110);
        bus.alu_flags_e = 4'b0100;
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 4'b0000);
        step();
        chk("cmp_flags", {12'd0, bus.flags_q}, 16'h4);
        chk("beq_taken", {15'd0, bus.pcsrc_e}, 16'd1);

        // CMP (Z clear) then BEQ
        drive(1'b0, 1'b0, 1'b0, 3'b001, 2'b11, 4'b1110);
        bus.alu_flags_e = 4'b0000;
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 4'b0000);
        step();
        chk("cmp2_flags", {12'd0, bus.flags_q}, 16'h0);
        chk("beq_not_taken", {15'd0, bus.pcsrc_e}, 16'd0);

        // flags=0100, STR NE then ADDS NE
        drive(1'b0, 1'b0, 1'b0, 3'b001, 2'b11, 4'b1110);
        bus.alu_flags_e = 4'b0100;
        step();
        drive(1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 4'b0001);
        step();
        chk("strne_memwrite", {15'd0, bus.memwrite_e}, 16'd0);
        chk("strne_cond_ex", {15'd0, bus.cond_ex_e}, 16'd0);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 2'b11, 4'b0001);
        bus.alu_flags_e = 4'b1111;
        step();
        chk("addsne_regwrite", {15'd0, bus.regwrite_e}, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 4'b1110);
        step();
        chk("addsne_flags_held", {12'd0, bus.flags_q}, 16'h4);

        // flags to 0000, then flagw=10 with 1011
        drive(1'b0, 1'b0, 1'b0, 3'b001, 2'b11, 4'b1110);
        bus.alu_flags_e = 4'b0000;
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 4'b1110);
        step();
        bus.alu_flags_e = 4'b1011;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 4'b1110);
        step();
        chk("flagw10_half", {12'd0, bus.flags_q}, 16'h8);

        // Stalled ADDS for 3 cycles, flags change each cycle
        drive(1'b0, 1'b1, 1'b0, 3'b000, 2'b11, 4'b1110);
        bus.alu_flags_e = 4'b0001;
        step();
        bus.stall_e = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b111, 2'b00, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            bus.alu_flags_e = 4'(i + 1);
            step();
            chk("stall_flags_frozen", {12'd0, bus.flags_q}, 16'h8);
            chk("stall_held_regwrite", {15'd0, bus.regwrite_e}, 16'd1);
        end
        bus.alu_flags_e = 4'b0110;
        bus.stall_e = 1'b0;
        step();
        chk("stall_release_flags", {12'd0, bus.flags_q}, 16'h6);
        chk("stall_next_aluc", {13'd0, bus.alucontrol_e}, 16'd7);

        // flush + stall together
        drive(1'b1, 1'b1, 1'b1, 3'b000, 2'b11, 4'b1110);
        step();
        bus.alu_flags_e = 4'b1111;
        bus.flush_e = 1'b1;
        bus.stall_e = 1'b1;
        step();
        chk("flush_valid", {15'd0, bus.valid_e}, 16'd0);
        chk("flush_gated", {13'd0, bus.pcsrc_e, bus.regwrite_e, bus.memwrite_e}, 16'd0);
        chk("flush_no_flagw", {12'd0, bus.flags_q}, 16'h6);
        bus.flush_e = 1'b0;
        bus.stall_e = 1'b0;

        // async reset mid-cycle
        drive(1'b1, 1'b1, 1'b1, 3'b101, 2'b11, 4'b1110);
        step();
        chk("prereset_valid", {15'd0, bus.valid_e}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 16'h0000);
        step();
        #3;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3'b011, 2'b00, 4'b1110);
        step();
        chk("post_reset_capture", {15'd0, bus.valid_e}, 16'd1);
        chk("post_reset_flags", {12'd0, bus.flags_q}, 16'h0);

        // cond x flags sweep
        for (int f = 0; f < 16; f++) begin
            drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b11, 4'b1110);
            bus.alu_flags_e = 4'(f);
            step();
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 4'(c));
                step();
                chk($sformatf("sweep_c%0d_f%0d", c, f),
                    {14'd0, bus.cond_ex_e, bus.regwrite_e},
                    {14'd0, model(4'(c), 4'(f)), model(4'(c), 4'(f))});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
